// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type and datapath widths for the convolution frame controller.
package conv_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
    localparam int NUM_TAPS = 9;
    localparam int WEIGHT_W = 8;
    localparam int ACC_W    = 32;
endpackage

// File: rtl/conv_tag_pipe.sv
// conv_tag_pipe: 1-bit delay line aligning window-valid tags with engine results.
module conv_tag_pipe #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tag,
    output logic o_tag
);
    logic [DEPTH-1:0] r_sr;

    always_ff @(posedge clk) begin
        if (rst) r_sr <= '0;
        else     r_sr <= (r_sr << 1) | DEPTH'(i_tag);
    end

    assign o_tag = r_sr[DEPTH-1];
endmodule

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame sequencing, weight shadowing and border filtering for a 3x3 conv engine.
// Optional CONV_CTRL_RELU_EN clamps negative results to zero.
module conv_frame_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int ENG_LATENCY = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [3:0]                   cfg_addr,
    input  logic [WEIGHT_W-1:0]          cfg_wdata,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic                         s_valid,
    input  logic [7:0]                   s_data,
    output logic                         s_ready,
    output logic                         eng_valid,
    output logic [7:0]                   eng_data,
    output logic [NUM_TAPS*WEIGHT_W-1:0] eng_weights,
    input  logic [ACC_W-1:0]             eng_out_pixel,
    input  logic                         eng_out_valid,
    output logic                         m_valid,
    output logic [ACC_W-1:0]             m_data,
    output logic                         m_last
);
    localparam int CW   = $clog2(IMG_WIDTH);
    localparam int RW   = $clog2(IMG_HEIGHT);
    localparam int NRES = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);
    localparam int NW   = $clog2(NRES + 1);

    state_t                       r_state, w_next;
    logic [WEIGHT_W-1:0]          r_w [NUM_TAPS];
    logic [NUM_TAPS*WEIGHT_W-1:0] r_shadow, w_flat;
    logic [CW-1:0]                r_col;
    logic [RW-1:0]                r_row;
    logic [NW-1:0]                r_cnt;
    logic                         w_start, w_xfer, w_last_px, w_tag, w_tag_d, w_emit;
    logic                         r_m_valid, r_m_last, r_done;
    logic [ACC_W-1:0]             r_m_data, w_res;

    always_comb begin
        w_start   = (r_state == ST_IDLE) && start;
        w_xfer    = (r_state == ST_RUN) && s_valid;
        w_last_px = w_xfer && (r_row == RW'(IMG_HEIGHT - 1)) && (r_col == CW'(IMG_WIDTH - 1));
        busy      = r_state != ST_IDLE;
        s_ready   = r_state == ST_RUN;
        w_next    = w_start ? ST_RUN :
                    w_last_px ? ST_DRAIN :
                    (r_state == ST_DRAIN && r_m_last) ? ST_IDLE : r_state;
    end

    always_comb begin
        w_flat = '0;
        for (int i = 0; i < NUM_TAPS; i++) w_flat[i*WEIGHT_W +: WEIGHT_W] = r_w[i];
    end

    // Only interior pixels complete a full 3x3 window; border results are dropped.
    assign w_tag  = w_xfer && (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_emit = eng_out_valid && w_tag_d;

`ifdef CONV_CTRL_RELU_EN
    assign w_res = eng_out_pixel[ACC_W-1] ? '0 : eng_out_pixel;
`else
    assign w_res = eng_out_pixel;
`endif

    conv_tag_pipe #(.DEPTH(ENG_LATENCY)) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_tag (w_tag),
        .o_tag (w_tag_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            for (int i = 0; i < NUM_TAPS; i++) r_w[i] <= '0;
            r_shadow  <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (cfg_we && cfg_addr < 4'(NUM_TAPS)) r_w[cfg_addr] <= cfg_wdata;
            if (w_start) begin
                r_shadow <= w_flat;
                r_col    <= '0;
                r_row    <= '0;
            end else if (w_xfer) begin
                r_col <= (r_col == CW'(IMG_WIDTH - 1)) ? '0 : r_col + 1'b1;
                r_row <= (r_col == CW'(IMG_WIDTH - 1)) ? r_row + 1'b1 : r_row;
            end
            if (w_start)     r_cnt <= '0;
            else if (w_emit) r_cnt <= r_cnt + 1'b1;
            r_m_valid <= w_emit;
            r_m_last  <= w_emit && (r_cnt == NW'(NRES - 1));
            r_m_data  <= w_res;
            r_done    <= (r_state == ST_DRAIN) && r_m_last;
        end
    end

    assign done        = r_done;
    assign eng_valid   = w_xfer;
    assign eng_data    = s_data;
    assign eng_weights = r_shadow;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign m_last      = r_m_last;
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// tb_conv_frame_ctrl: randomized frames against a 3x3 convolution reference with a modelled engine.
module tb_conv_frame_ctrl;
    localparam int W = 4;
    localparam int H = 4;
    localparam int L = 8;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst, cfg_we, start, s_valid;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_wdata, s_data;
    logic        busy, done, s_ready, eng_valid, m_valid, m_last;
    logic [7:0]  eng_data;
    logic [71:0] eng_weights;
    logic [31:0] m_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tb_w [9];
    int fr_w [9];
    int fp [N];
    int got_q [$];
    bit last_q [$];
    int done_cnt, done_cyc, last_cyc, e_cnt, e_idx, e_v;
    int e_buf [N];
    logic [L-1:0] ep_v = '0;
    logic [31:0]  ep_d [L];

    always #5 clk = ~clk;

    conv_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ENG_LATENCY(L)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .eng_valid     (eng_valid),
        .eng_data      (eng_data),
        .eng_weights   (eng_weights),
        .eng_out_pixel (ep_d[L-1]),
        .eng_out_valid (ep_v[L-1]),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_last        (m_last)
    );

    // Engine model: full 3x3 result for interior pixels, random junk elsewhere, fixed latency.
    function automatic int eng_conv(input int idx);
        int s = 0;
        for (int n = 0; n < 9; n++)
            s += int'($signed(eng_weights[8*n +: 8])) * e_buf[(idx/W - 2 + n/3)*W + idx%W - 2 + n%3];
        return s;
    endfunction

    always @(posedge clk) begin
        cyc++;
        e_v = 0;
        if (rst || (start && !busy)) e_idx = 0;
        else if (eng_valid) begin
            e_buf[e_idx] = int'(eng_data);
            e_v = (e_idx/W >= 2 && e_idx%W >= 2) ? eng_conv(e_idx) : int'($urandom);
            e_idx = (e_idx + 1) % N;
            e_cnt++;
        end
        ep_v <= {ep_v[L-2:0], eng_valid};
        ep_d[0] <= e_v;
        for (int i = 1; i < L; i++) ep_d[i] <= ep_d[i-1];
    end

    always @(negedge clk) begin
        if (m_valid) begin
            got_q.push_back(int'($signed(m_data)));
            last_q.push_back(m_last);
            if (m_last) last_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic int ref_px(input int r, input int c);
        int s = 0;
        for (int n = 0; n < 9; n++) s += fr_w[n] * fp[(r - 2 + n/3)*W + c - 2 + n%3];
`ifdef CONV_CTRL_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    function automatic logic [71:0] packw(input int w [9]);
        logic [71:0] p;
        for (int n = 0; n < 9; n++) p[8*n +: 8] = 8'(w[n]);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int a, input int d);
        cfg_we = 1'b1; cfg_addr = a[3:0]; cfg_wdata = d[7:0];
        tick();
        cfg_we = 1'b0;
        if (a < 9) tb_w[a] = int'($signed(d[7:0]));
    endtask

    task automatic set_all(input int d);
        for (int n = 0; n < 9; n++) cfg(n, d);
    endtask

    task automatic do_start(input bit with_cfg);
        start = 1'b1;
        if (with_cfg) begin cfg_we = 1'b1; cfg_addr = 4'd4; cfg_wdata = 8'd9; end
        fr_w = tb_w;
        tick();
        start = 1'b0; cfg_we = 1'b0;
        if (with_cfg) tb_w[4] = 9;
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            errors++; $display("FAIL start_run busy=%b s_ready=%b exp 1/1", busy, s_ready);
        end
        checks++;
        if (eng_weights !== packw(fr_w)) begin
            errors++; $display("FAIL shadow got %h exp %h", eng_weights, packw(fr_w));
        end
    endtask

    // mode 0: back-to-back, 1: alternate idle cycles, 2: random gaps and junk while draining
    task automatic stream(input int mode, input bit mid_act);
        for (int i = 0; i < N; i++) begin
            if (mid_act && i == 6) begin
                s_valid = 1'b0; start = 1'b1;
                cfg_we = 1'b1; cfg_addr = 4'd4; cfg_wdata = 8'd3;
                tick();
                start = 1'b0; cfg_addr = 4'd12; cfg_wdata = 8'h55;
                tick();
                cfg_we = 1'b0; tb_w[4] = 3;
                checks++;
                if (busy !== 1'b1 || s_ready !== 1'b1 || eng_weights !== packw(fr_w)) begin
                    errors++; $display("FAIL mid_frame_ignore busy=%b w=%h exp 1 %h", busy, eng_weights, packw(fr_w));
                end
            end
            if (mode == 2) repeat ($urandom_range(0, 2)) begin s_valid = 1'b0; tick(); end
            s_valid = 1'b1; s_data = 8'(fp[i]);
            tick();
            if (mode == 1) begin s_valid = 1'b0; tick(); end
        end
        s_valid = (mode == 2); s_data = 8'($urandom);
    endtask

    task automatic run_frame(input string nm, input int mode, input bit mid_act, input bit with_cfg);
        int exp_v [4];
        got_q.delete(); last_q.delete();
        done_cnt = 0; done_cyc = -1; last_cyc = -1; e_cnt = 0;
        do_start(with_cfg);
        stream(mode, mid_act);
        for (int k = 0; k < 200 && done_cnt == 0; k++) tick();
        s_valid = 1'b0;
        repeat (4) tick();
        for (int r = 2; r < H; r++) for (int c = 2; c < W; c++) exp_v[(r-2)*(W-2) + c - 2] = ref_px(r, c);
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL %s done_pulses got %0d exp 1", nm, done_cnt); end
        checks++;
        if (got_q.size() != 4) begin errors++; $display("FAIL %s result_count got %0d exp 4", nm, got_q.size()); end
        for (int j = 0; j < 4 && j < got_q.size(); j++) begin
            checks++;
            if (got_q[j] != exp_v[j] || last_q[j] != (j == 3)) begin
                errors++;
                $display("FAIL %s result%0d got %0d last=%0d exp %0d last=%0d", nm, j, got_q[j], last_q[j], exp_v[j], j == 3);
            end
        end
        checks++;
        if (done_cyc != last_cyc + 1) begin errors++; $display("FAIL %s done_timing got cyc %0d exp %0d", nm, done_cyc, last_cyc + 1); end
        checks++;
        if (e_cnt != N || busy !== 1'b0) begin errors++; $display("FAIL %s eng_transfers got %0d busy=%b exp %0d busy=0", nm, e_cnt, busy, N); end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b1; s_data = 8'hAA;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, done, s_ready, eng_valid, m_valid, m_last} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 000000", {busy, done, s_ready, eng_valid, m_valid, m_last});
        end
        checks++;
        if (m_data !== 32'd0 || eng_weights !== 72'd0) begin
            errors++; $display("FAIL reset_data got %h/%h exp 0/0", m_data, eng_weights);
        end
        s_valid = 1'b0;
        for (int n = 0; n < 9; n++) tb_w[n] = 0;
    endtask

    task automatic test_identity();
        set_all(0); cfg(4, 1);
        for (int i = 0; i < N; i++) fp[i] = i;
        run_frame("identity", 0, 1'b0, 1'b0);
        run_frame("toggle_start_cfg", 1, 1'b0, 1'b1);
    endtask

    task automatic test_constant();
        set_all(1);
        for (int i = 0; i < N; i++) fp[i] = 2;
        run_frame("all_ones", 0, 1'b0, 1'b0);
        set_all(-1);
        run_frame("all_neg", 2, 1'b0, 1'b0);
    endtask

    task automatic test_mid_cfg();
        set_all(0); cfg(4, 1);
        for (int i = 0; i < N; i++) fp[i] = i;
        run_frame("mid_cfg_cur", 0, 1'b1, 1'b0);
        run_frame("mid_cfg_next", 0, 1'b0, 1'b0);
    endtask

    task automatic test_rst_midframe();
        set_all(7);
        for (int i = 0; i < N; i++) fp[i] = i;
        got_q.delete(); done_cnt = 0;
        do_start(1'b0);
        for (int i = 0; i < 7; i++) begin s_valid = 1'b1; s_data = 8'(fp[i]); tick(); end
        s_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 9; n++) tb_w[n] = 0;
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL rst_abort busy=%b s_ready=%b exp 0/0", busy, s_ready); end
        repeat (20) tick();
        checks++;
        if (got_q.size() != 0 || done_cnt != 0) begin
            errors++; $display("FAIL rst_inflight results=%0d done=%0d exp 0/0", got_q.size(), done_cnt);
        end
        checks++;
        if (eng_weights !== 72'd0) begin errors++; $display("FAIL rst_shadow got %h exp 0", eng_weights); end
        cfg(4, 1);
        run_frame("after_rst", 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            repeat (12) cfg($urandom_range(0, 15), $urandom_range(0, 255));
            for (int i = 0; i < N; i++) fp[i] = $urandom_range(0, 255);
            run_frame("random", 2, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; s_valid = 1'b0; s_data = '0;
        e_cnt = 0; e_idx = 0; done_cnt = 0;
        test_reset();
        test_identity();
        test_constant();
        test_mid_cfg();
        test_rst_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
